// File: rtl/uart_rx_fsm.sv
// UART receive front end: 2-flop synchroniser, oversampled start/data/parity/stop
// sampling, and a one-clk strobe to the downstream parity checker.
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       parity_bit,
  output logic       parity_load,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int            CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID_BIT   = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          parity_bit_q, parity_bit_d;
  logic          done_q, done_d;
  logic          stop_ok_q, stop_ok_d;
  logic          parity_load_q, rx_valid_q, frame_error_q;

  // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_d       = data_q;
    parity_bit_d = parity_bit_q;
    stop_ok_d    = stop_ok_q;
    done_d       = 1'b0;

    if (baud_tick) begin
      tick_cnt_d = (tick_cnt_q == MID_BIT) ? '0 : tick_cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          tick_cnt_d = '0;
          if (!rx_s_q) state_d = S_START;
        end
        S_START: begin
          // Re-check the line half a bit after the edge to reject glitches.
          if (tick_cnt_q == MID_START) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tick_cnt_q == MID_BIT) begin
            shift_d    = {rx_s_q, shift_q[7:1]};
            bit_idx_d  = bit_idx_q + 1'b1;
            tick_cnt_d = '0;
            if (bit_idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (tick_cnt_q == MID_BIT) begin
            par_d      = rx_s_q;
            tick_cnt_d = '0;
            state_d    = S_STOP;
          end
        end
        S_STOP: begin
          // Return to IDLE at mid-stop so a back-to-back start edge is not missed.
          if (tick_cnt_q == MID_BIT) begin
            data_d       = shift_q;
            parity_bit_d = PARITY_EN ? par_q : 1'b0;
            stop_ok_d    = rx_s_q;
            done_d       = 1'b1;
            tick_cnt_d   = '0;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      tick_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      data_q        <= '0;
      parity_bit_q  <= 1'b0;
      stop_ok_q     <= 1'b0;
      done_q        <= 1'b0;
      parity_load_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx_in;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      data_q        <= data_d;
      parity_bit_q  <= parity_bit_d;
      stop_ok_q     <= stop_ok_d;
      done_q        <= done_d;
      // Strobes trail the data_out update by one clk, so data is stable while they are high.
      parity_load_q <= done_q;
      rx_valid_q    <= done_q & stop_ok_q;
      frame_error_q <= done_q & ~stop_ok_q;
    end
  end

  assign data_out    = data_q;
  assign parity_bit  = parity_bit_q;
  assign parity_load = parity_load_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != S_IDLE);

endmodule
